dmem_responder: RTL

//  Responder end of the pipeline's data-memory request interface (wr_en/rd_en/addr/wdata -> rdata).

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder that holds the pipeline via stall per access.
// Define DMEM_BYTE_EN for RV32I byte/halfword loads and stores; otherwise every access is a word.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic        req_re,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        req_ready,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          DATA_W   = 32;
    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [31:0]       off;
    logic              req_err;
    logic [AW-1:0]     idx_p0;
    logic              we_p0;
    logic              err_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] rword;
    logic [DATA_W-1:0] wword;
    logic [DATA_W-1:0] load_val;
    logic [3:0]        be;
    logic              do_access;

`ifdef DMEM_BYTE_EN
    logic [1:0]        lane_p0;
    logic [2:0]        size_p0;

    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                       input logic [1:0]        lane,
                                                       input logic [2:0]        size);
        logic [DATA_W-1:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (size)
            3'b000:  return {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  return {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  return {24'd0, shifted[7:0]};
            3'b101:  return {16'd0, shifted[15:0]};
            default: return word;
        endcase
    endfunction
`else
    logic unused_size;
    assign unused_size = ^req_size;
`endif

    // Request decode: legality is settled at acceptance so the access stage only gates on err_p0.
    always_comb begin
        off     = req_addr - BASE_ADDR;
        req_err = (req_we == req_re) || (req_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
`ifdef DMEM_BYTE_EN
        case (req_size)
            3'b000:  ;
            3'b001:  if (req_addr[0]) req_err = 1'b1;
            3'b010:  if (req_addr[1:0] != 2'b00) req_err = 1'b1;
            3'b100:  if (req_we) req_err = 1'b1;
            3'b101:  if (req_we || req_addr[0]) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
`else
        if (req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
    end

    assign stall     = ((state == IDLE) && req_valid) || (state == WAIT);
    assign do_access = (state == WAIT) && (cnt == 4'd0);

    // Capture stage: request fields held for the whole WAIT period.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req_valid) begin
            idx_p0   <= off[AW+1:2];
            we_p0    <= req_we;
            err_p0   <= req_err;
            wdata_p0 <= req_wdata;
`ifdef DMEM_BYTE_EN
            lane_p0  <= req_addr[1:0];
            size_p0  <= req_size;
`endif
        end
    end

    // Access stage: byte lanes and load extraction for the latched request.
    always_comb begin
        rword    = mem[idx_p0];
        be       = 4'b1111;
        wword    = wdata_p0;
        load_val = rword;
`ifdef DMEM_BYTE_EN
        load_val = load_extract(rword, lane_p0, size_p0);
        case (size_p0[1:0])
            2'b00:   begin be = 4'b0001 << lane_p0; wword = {4{wdata_p0[7:0]}}; end
            2'b01:   begin be = 4'b0011 << lane_p0; wword = {2{wdata_p0[15:0]}}; end
            default: ;
        endcase
`endif
    end

    // Storage is never reset; a reset during WAIT leaves state IDLE so the write never fires.
    always_ff @(posedge clk) begin
        if (do_access && we_p0 && !err_p0) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_p0][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= WAIT;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err_p0;
                        rsp_rdata <= (err_p0 || we_p0) ? '0 : load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
